// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types, quarter-round index table and rotate helper for the ChaCha engine
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam int ROT_A = 16;
  localparam int ROT_B = 12;
  localparam int ROT_C = 8;
  localparam int ROT_D = 7;

  // Rows 0-3 are the column rounds, rows 4-7 the diagonal rounds.
  localparam logic [3:0] QR_IDX [8][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15},
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_block_engine_qr.sv
// rtl/chacha_block_engine_qr.sv - combinational ChaCha quarter-round
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  word_t i_c,
  input  word_t i_d,
  output word_t o_a,
  output word_t o_b,
  output word_t o_c,
  output word_t o_d
);

  word_t w_a1, w_b1, w_c1, w_d1;

  assign w_a1 = i_a + i_b;
  assign w_d1 = rotl(i_d ^ w_a1, ROT_A);
  assign w_c1 = i_c + w_d1;
  assign w_b1 = rotl(i_b ^ w_c1, ROT_B);
  assign o_a  = w_a1 + w_b1;
  assign o_d  = rotl(w_d1 ^ o_a, ROT_C);
  assign o_c  = w_c1 + o_d;
  assign o_b  = rotl(w_b1 ^ o_c, ROT_D);

endmodule

// File: rtl/chacha_block_engine.sv
// rtl/chacha_block_engine.sv - iterative ChaCha block engine with byte-wide host access
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int ROUNDS   = 20,
  parameter int FEED_FWD = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       start,
  output logic       busy,
  output logic       done
);

  localparam int         STEPS     = 8 / LANES;
  localparam int         DBL_W     = (ROUNDS / 2 > 1) ? $clog2(ROUNDS / 2) : 1;
  localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);
  localparam logic [DBL_W-1:0] DBL_LAST = DBL_W'(ROUNDS / 2 - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("chacha_block_engine: LANES must be 1, 2 or 4");
  end
  if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_bad_rounds
    $error("chacha_block_engine: ROUNDS must be even and at least 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ADD} state_e;

  state_e           r_state;
  word_t            r_s    [16];
  word_t            r_init [16];
  logic [2:0]       r_step;
  logic [DBL_W-1:0] r_dbl;
  logic             r_busy;
  logic             r_done;

  logic [2:0] w_q   [LANES];
  word_t      w_in  [LANES][4];
  word_t      w_out [LANES][4];
  word_t      w_word;

  // Lanes in one step cover consecutive q values, so they stay within one half of the table.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_q[l] = 3'(int'(r_step) * LANES + l);
    for (genvar k = 0; k < 4; k++) begin : g_sel
      assign w_in[l][k] = r_s[QR_IDX[w_q[l]][k]];
    end
    chacha_qr u_qr (
      .i_a(w_in[l][0]),  .i_b(w_in[l][1]),  .i_c(w_in[l][2]),  .i_d(w_in[l][3]),
      .o_a(w_out[l][0]), .o_b(w_out[l][1]), .o_c(w_out[l][2]), .o_d(w_out[l][3])
    );
  end

  assign w_word = r_s[addr[5:2]];
  assign rdata  = w_word[{addr[1:0], 3'b000} +: 8];
  assign busy   = r_busy;
  assign done   = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_dbl   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_s[i]    <= '0;
        r_init[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wr_en) begin
            r_s[addr[5:2]][{addr[1:0], 3'b000} +: 8] <= wdata;
          end else if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_step  <= '0;
            r_dbl   <= '0;
            if (FEED_FWD != 0) begin
              for (int i = 0; i < 16; i++) r_init[i] <= r_s[i];
            end
          end
        end
        ST_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 4; k++) r_s[QR_IDX[w_q[l]][k]] <= w_out[l][k];
          end
          if (r_step == STEP_LAST) begin
            r_step <= '0;
            if (r_dbl == DBL_LAST) begin
              if (FEED_FWD != 0) begin
                r_state <= ST_ADD;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_dbl <= r_dbl + 1'b1;
            end
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        ST_ADD: begin
          for (int i = 0; i < 16; i++) r_s[i] <= r_s[i] + r_init[i];
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_engine.sv
// tb/tb_chacha_block_engine.sv - self-checking bench for chacha_block_engine across lane/round/feed-forward variants
`timescale 1ns/1ps
module tb_chacha_block_engine;

  typedef logic [15:0][31:0] blk_t;

  localparam int NI = 5;
  localparam int L_LANES  [NI] = '{1, 2, 4, 1, 1};
  localparam int L_ROUNDS [NI] = '{20, 20, 20, 20, 8};
  localparam int L_FF     [NI] = '{1, 1, 1, 0, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [5:0]    addr;
  logic [7:0]    wdata;
  logic [NI-1:0] start_v;
  logic [7:0]    rdata_v [NI];
  logic [NI-1:0] busy_v;
  logic [NI-1:0] done_v;

  logic [31:0] qa, qb, qc, qd, qoa, qob, qoc, qod;

  int checks = 0;
  int failures = 0;

  int lat [NI];
  int lat2 [NI];
  int ndone [NI];
  logic [NI-1:0] busy_bad;

  always #5 clk = ~clk;

  chacha_block_engine #(.LANES(1), .ROUNDS(20), .FEED_FWD(1)) u_e0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_v[0]),
    .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  chacha_block_engine #(.LANES(2), .ROUNDS(20), .FEED_FWD(1)) u_e1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_v[1]),
    .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  chacha_block_engine #(.LANES(4), .ROUNDS(20), .FEED_FWD(1)) u_e2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_v[2]),
    .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  chacha_block_engine #(.LANES(1), .ROUNDS(20), .FEED_FWD(0)) u_e3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_v[3]),
    .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  chacha_block_engine #(.LANES(1), .ROUNDS(8), .FEED_FWD(1)) u_e4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_v[4]),
    .start(start_v[4]), .busy(busy_v[4]), .done(done_v[4]));

  chacha_qr u_qr (
    .i_a(qa), .i_b(qb), .i_c(qc), .i_d(qd),
    .o_a(qoa), .o_b(qob), .o_c(qoc), .o_d(qod));

  // Reference model: textbook ChaCha block function on a plain 16-word array.
  function automatic logic [31:0] m_rotl(logic [31:0] x, int n);
    return {x, x} >> (32 - n);
  endfunction

  function automatic logic [3:0][31:0] m_qr(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    a = a + b; d = m_rotl(d ^ a, 16);
    c = c + d; b = m_rotl(b ^ c, 12);
    a = a + b; d = m_rotl(d ^ a, 8);
    c = c + d; b = m_rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic blk_t m_qrs(blk_t x, int a, int b, int c, int d);
    logic [3:0][31:0] r;
    r = m_qr(x[a], x[b], x[c], x[d]);
    x[a] = r[0]; x[b] = r[1]; x[c] = r[2]; x[d] = r[3];
    return x;
  endfunction

  function automatic blk_t m_block(blk_t in, int rounds, int ff);
    blk_t x = in;
    for (int r = 0; r < rounds / 2; r++) begin
      x = m_qrs(x, 0, 4, 8, 12); x = m_qrs(x, 1, 5, 9, 13);
      x = m_qrs(x, 2, 6, 10, 14); x = m_qrs(x, 3, 7, 11, 15);
      x = m_qrs(x, 0, 5, 10, 15); x = m_qrs(x, 1, 6, 11, 12);
      x = m_qrs(x, 2, 7, 8, 13);  x = m_qrs(x, 3, 4, 9, 14);
    end
    if (ff != 0) for (int i = 0; i < 16; i++) x[i] = x[i] + in[i];
    return x;
  endfunction

  function automatic int exp_lat(int i);
    return L_ROUNDS[i] * 4 / L_LANES[i] + L_FF[i];
  endfunction

  function automatic blk_t rand_blk();
    blk_t x;
    for (int i = 0; i < 16; i++) x[i] = $urandom;
    return x;
  endfunction

  function automatic blk_t rfc_blk();
    blk_t x;
    x[0] = 32'h61707865; x[1] = 32'h3320646e; x[2] = 32'h79622d32; x[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      x[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    x[12] = 32'h00000001; x[13] = 32'h09000000; x[14] = 32'h4a000000; x[15] = 32'h00000000;
    return x;
  endfunction

  task automatic write_state(input blk_t st);
    for (int w = 0; w < 16; w++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        wr_en = 1'b1;
        addr  = {w[3:0], b[1:0]};
        wdata = st[w][8*b +: 8];
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_state(input int i, output blk_t st);
    for (int w = 0; w < 16; w++) begin
      for (int b = 0; b < 4; b++) begin
        addr = {w[3:0], b[1:0]};
        #1;
        st[w][8*b +: 8] = rdata_v[i];
      end
    end
  endtask

  // mode 0: plain run; 1: restart each instance in its done cycle; 2: poke start/wr_en while busy
  task automatic start_and_watch(input int budget, input int mode);
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1; lat2[i] = -1; ndone[i] = 0;
    end
    busy_bad = '0;
    @(negedge clk);
    start_v = '1;
    @(posedge clk); #1;
    start_v = '0;
    checks++;
    if (busy_v !== {NI{1'b1}}) begin
      failures++;
      $display("FAIL busy_after_start got=%b exp=%b", busy_v, {NI{1'b1}});
    end
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start_v = '0;
      if (mode == 2 && c == 7) wr_en = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] < 0 && c < exp_lat(i) && !busy_v[i]) busy_bad[i] = 1'b1;
        if (done_v[i]) begin
          ndone[i]++;
          if (lat[i] < 0) begin
            lat[i] = c;
            if (busy_v[i]) busy_bad[i] = 1'b1;
            if (mode == 1) start_v[i] = 1'b1;
          end else if (lat2[i] < 0) begin
            lat2[i] = c - lat[i] - 1;
          end
        end
      end
      if (mode == 2 && c == 5) start_v = '1;
      if (mode == 2 && c == 6) begin
        wr_en = 1'b1; addr = 6'($urandom); wdata = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    blk_t got;
    int nd;
    checks++;
    if (busy_v !== '0 || done_v !== '0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b exp=0", busy_v, done_v);
    end
    for (int i = 0; i < NI; i++) begin
      read_state(i, got);
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%h exp=0", i, got);
      end
    end
    write_state(rand_blk());
    @(negedge clk); start_v = '1;
    @(negedge clk); start_v = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy_v !== '0 || done_v !== '0) begin
      failures++;
      $display("FAIL abort_flags busy=%b done=%b exp=0", busy_v, done_v);
    end
    for (int i = 0; i < NI; i++) begin
      read_state(i, got);
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL abort_state inst=%0d got=%h exp=0", i, got);
      end
    end
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done_v !== '0 || busy_v !== '0) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL abort_quiet active_cycles=%0d exp=0", nd);
    end
    start_and_watch(120, 0);
    for (int i = 0; i < NI; i++) begin
      read_state(i, got);
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL zero_block inst=%0d got=%h exp=0", i, got);
      end
    end
  endtask

  task automatic test_qr();
    logic [3:0][31:0] e;
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    checks++;
    if ({qod, qoc, qob, qoa} !== {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4}) begin
      failures++;
      $display("FAIL qr_vector got=%h %h %h %h exp=ea2a92f4 cb1cf8ce 4581472e 5881c4bb", qoa, qob, qoc, qod);
    end
    for (int t = 0; t < 8; t++) begin
      qa = $urandom; qb = $urandom; qc = $urandom; qd = $urandom;
      #1;
      e = m_qr(qa, qb, qc, qd);
      checks++;
      if ({qod, qoc, qob, qoa} !== e) begin
        failures++;
        $display("FAIL qr_random got=%h exp=%h", {qod, qoc, qob, qoa}, e);
      end
    end
  endtask

  task automatic check_run(input string name, input blk_t in, input int nd_exp, input int passes);
    blk_t got, exp;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (lat[i] != exp_lat(i)) begin
        failures++;
        $display("FAIL %s_latency inst=%0d got=%0d exp=%0d", name, i, lat[i], exp_lat(i));
      end
      checks++;
      if (ndone[i] != nd_exp || busy_bad[i]) begin
        failures++;
        $display("FAIL %s_done_busy inst=%0d dones=%0d exp=%0d busy_bad=%b", name, i, ndone[i], nd_exp, busy_bad[i]);
      end
      exp = in;
      for (int p = 0; p < passes; p++) exp = m_block(exp, L_ROUNDS[i], L_FF[i]);
      read_state(i, got);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_state inst=%0d got=%h exp=%h", name, i, got, exp);
      end
    end
  endtask

  task automatic test_rfc_block();
    blk_t got;
    write_state(rfc_blk());
    start_and_watch(120, 0);
    check_run("rfc", rfc_blk(), 1, 1);
    read_state(0, got);
    checks++;
    if (got[0] !== 32'he4e7f110 || got[1] !== 32'h15593bd1) begin
      failures++;
      $display("FAIL rfc_words got=%h %h exp=e4e7f110 15593bd1", got[0], got[1]);
    end
    addr = 6'd0; #1;
    checks++;
    if (rdata_v[0] !== 8'h10) begin
      failures++;
      $display("FAIL rfc_rdata0 got=%h exp=10", rdata_v[0]);
    end
    addr = 6'd1; #1;
    checks++;
    if (rdata_v[0] !== 8'hf1) begin
      failures++;
      $display("FAIL rfc_rdata1 got=%h exp=f1", rdata_v[0]);
    end
    read_state(3, got);
    checks++;
    if (got[0] !== 32'h837778ab) begin
      failures++;
      $display("FAIL rfc_noff_word0 got=%h exp=837778ab", got[0]);
    end
  endtask

  task automatic test_random_blocks();
    blk_t st;
    for (int t = 0; t < 3; t++) begin
      st = rand_blk();
      write_state(st);
      start_and_watch(120, 0);
      check_run("random", st, 1, 1);
    end
  endtask

  task automatic test_write_with_start();
    logic [5:0] a;
    logic [7:0] d;
    a = 6'($urandom); d = 8'($urandom);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1; start_v = '1;
    @(negedge clk);
    wr_en = 1'b0; start_v = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_v !== '0) begin
      failures++;
      $display("FAIL wr_start_busy got=%b exp=0", busy_v);
    end
    addr = a; #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_v[i] !== d) begin
        failures++;
        $display("FAIL wr_start_byte inst=%0d got=%h exp=%h", i, rdata_v[i], d);
      end
    end
  endtask

  task automatic test_busy_ignore();
    blk_t st;
    st = rand_blk();
    write_state(st);
    start_and_watch(200, 2);
    check_run("busy_poke", st, 1, 1);
  endtask

  task automatic test_back_to_back();
    blk_t st;
    st = rand_blk();
    write_state(st);
    start_and_watch(200, 1);
    check_run("b2b", st, 2, 2);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (lat2[i] != exp_lat(i)) begin
        failures++;
        $display("FAIL b2b_latency2 inst=%0d got=%0d exp=%0d", i, lat2[i], exp_lat(i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; addr = '0; wdata = '0; start_v = '0;
    qa = '0; qb = '0; qc = '0; qd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_qr();
    test_rfc_block();
    test_random_blocks();
    test_write_with_start();
    test_busy_ignore();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
